// File: rtl/me_stage_unit_pkg.sv
// Shared types and constants for the memory-access (ME) pipeline stage.
// Bus widths, field offsets and load-op encodings used by the stage and its testbench.
package me_stage_unit_pkg;

  localparam int unsigned EX_BUS_W  = 74;
  localparam int unsigned WB_BUS_W  = 70;
  localparam int unsigned FWD_BUS_W = 38;

  // EX->ME bus: {pc, gr_we, dest, alu_result, mem_req, load_op}
  localparam int unsigned EX_PC_LSB      = 42;
  localparam int unsigned EX_GR_WE_BIT   = 41;
  localparam int unsigned EX_DEST_LSB    = 36;
  localparam int unsigned EX_ALU_LSB     = 4;
  localparam int unsigned EX_MEM_REQ_BIT = 3;
  localparam int unsigned EX_LOAD_OP_LSB = 0;

  // ME->WB bus: {pc, gr_we, dest, final_result}
  localparam int unsigned WB_PC_LSB     = 38;
  localparam int unsigned WB_GR_WE_BIT  = 37;
  localparam int unsigned WB_DEST_LSB   = 32;
  localparam int unsigned WB_RESULT_LSB = 0;

  // Forwarding bus: {load_wait, dest, final_result}
  localparam int unsigned FWD_LOAD_WAIT_BIT = 37;
  localparam int unsigned FWD_DEST_LSB      = 32;
  localparam int unsigned FWD_RESULT_LSB    = 0;

  localparam logic [2:0] LOAD_OP_B  = 3'd0;
  localparam logic [2:0] LOAD_OP_H  = 3'd1;
  localparam logic [2:0] LOAD_OP_W  = 3'd2;
  localparam logic [2:0] LOAD_OP_BU = 3'd3;
  localparam logic [2:0] LOAD_OP_HU = 3'd4;

  typedef enum logic [1:0] {
    StEmpty,
    StWait,
    StReady
  } me_state_e;

endpackage

// File: rtl/me_stage_unit_if.sv
// Signal bundle for the ME stage: EX input handshake, data-SRAM response, WB output and forwarding.
// master = the ME stage itself, slave = its surroundings.
interface me_stage_unit_if;
  import me_stage_unit_pkg::*;

  logic                 ME_Allow_in;
  logic                 EX_to_ME_Valid;
  logic [EX_BUS_W-1:0]  EX_to_ME_Bus;
  logic                 data_sram_data_ok;
  logic [31:0]          data_sram_rdata;
  logic                 WB_Allow_in;
  logic                 ME_to_WB_Valid;
  logic [WB_BUS_W-1:0]  ME_to_WB_Bus;
  logic [FWD_BUS_W-1:0] ME_Forward;

  modport master (
    output ME_Allow_in,
    output ME_to_WB_Valid,
    output ME_to_WB_Bus,
    output ME_Forward,
    input  EX_to_ME_Valid,
    input  EX_to_ME_Bus,
    input  data_sram_data_ok,
    input  data_sram_rdata,
    input  WB_Allow_in
  );

  modport slave (
    input  ME_Allow_in,
    input  ME_to_WB_Valid,
    input  ME_to_WB_Bus,
    input  ME_Forward,
    output EX_to_ME_Valid,
    output EX_to_ME_Bus,
    output data_sram_data_ok,
    output data_sram_rdata,
    output WB_Allow_in
  );

endinterface

// File: rtl/me_load_align.sv
// Load-data alignment: picks the addressed byte/half of the returned word and extends it.
module me_load_align
  import me_stage_unit_pkg::*;
(
  input  logic [2:0]  load_op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // offset_i[0] is ignored for halves: misaligned halves trap in EX
  assign shifted  = word_i >> {offset_i, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    result_o = word_i;
    case (load_op_i)
      LOAD_OP_B:  result_o = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_H:  result_o = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_BU: result_o = {24'h0, byte_sel};
      LOAD_OP_HU: result_o = {16'h0, half_sel};
      default:    result_o = word_i;
    endcase
  end

endmodule

// File: rtl/me_stage_unit.sv
// ME pipeline stage: holds one EX instruction, waits for load data, buffers it under WB
// backpressure, and produces the ME->WB bus and the decoder forwarding/stall bus.
module me_stage_unit
  import me_stage_unit_pkg::*;
(
  input logic             clk,
  input logic             reset,
  me_stage_unit_if.master me_if
);

  logic [EX_BUS_W-1:0] ex_q;
  logic                me_valid_q;
  logic                buf_valid_q;
  logic [31:0]         buf_data_q;

  logic [31:0] ex_pc;
  logic        ex_gr_we;
  logic [4:0]  ex_dest;
  logic [31:0] ex_alu_result;
  logic        ex_mem_req;
  logic [2:0]  ex_load_op;

  me_state_e   state;
  logic        ready_go;
  logic        allow_in;
  logic        accept;
  logic        capture;
  logic        load_wait;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ex_pc         = ex_q[EX_PC_LSB +: 32];
  assign ex_gr_we      = ex_q[EX_GR_WE_BIT];
  assign ex_dest       = ex_q[EX_DEST_LSB +: 5];
  assign ex_alu_result = ex_q[EX_ALU_LSB +: 32];
  assign ex_mem_req    = ex_q[EX_MEM_REQ_BIT];
  assign ex_load_op    = ex_q[EX_LOAD_OP_LSB +: 3];

  // Stage state is a view of the registers plus the live data_ok strobe
  always_comb begin
    state = StReady;
    if (!me_valid_q) begin
      state = StEmpty;
    end else if (ex_mem_req && !buf_valid_q && !me_if.data_sram_data_ok) begin
      state = StWait;
    end
  end

  assign ready_go  = (state != StWait);
  assign allow_in  = (state == StEmpty) || (ready_go && me_if.WB_Allow_in);
  assign accept    = me_if.EX_to_ME_Valid && allow_in;
  assign load_wait = (state == StWait);
  assign capture   = me_if.data_sram_data_ok && me_valid_q && ex_mem_req && !buf_valid_q &&
                     !me_if.WB_Allow_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      me_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      if (allow_in) begin
        me_valid_q <= me_if.EX_to_ME_Valid;
      end
      if (accept) begin
        buf_valid_q <= 1'b0;
      end else if (capture) begin
        buf_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ex_q <= me_if.EX_to_ME_Bus;
    end
    if (capture) begin
      buf_data_q <= me_if.data_sram_rdata;
    end
  end

  assign load_word = buf_valid_q ? buf_data_q : me_if.data_sram_rdata;

  me_load_align u_load_align (
    .load_op_i (ex_load_op),
    .offset_i  (ex_alu_result[1:0]),
    .word_i    (load_word),
    .result_o  (load_data)
  );

  assign final_result = ex_mem_req ? load_data : ex_alu_result;

  always_comb begin
    me_if.ME_Allow_in    = allow_in;
    me_if.ME_to_WB_Valid = (state == StReady);
    me_if.ME_to_WB_Bus   = '0;
    me_if.ME_to_WB_Bus[WB_PC_LSB +: 32]     = ex_pc;
    me_if.ME_to_WB_Bus[WB_GR_WE_BIT]        = ex_gr_we;
    me_if.ME_to_WB_Bus[WB_DEST_LSB +: 5]    = ex_dest;
    me_if.ME_to_WB_Bus[WB_RESULT_LSB +: 32] = final_result;
    me_if.ME_Forward     = '0;
    me_if.ME_Forward[FWD_LOAD_WAIT_BIT]     = load_wait;
    me_if.ME_Forward[FWD_DEST_LSB +: 5]     = ex_dest & {5{me_valid_q}};
    me_if.ME_Forward[FWD_RESULT_LSB +: 32]  = final_result;
  end

  // data_ok must belong to the load currently held in the stage
  a_data_ok_has_load: assert property (@(posedge clk) disable iff (reset)
    me_if.data_sram_data_ok |-> (me_valid_q && ex_mem_req));

  a_no_second_data_ok: assert property (@(posedge clk) disable iff (reset)
    me_if.data_sram_data_ok |-> !(me_valid_q && buf_valid_q));

endmodule

// File: doc/me_stage_unit.md
Name: me_stage_unit

Overview:
Memory-access pipeline stage and producer side of the ME->WB valid/allow-in handshake.
- Accepts EX-stage instructions and waits for the data-SRAM read response on loads.
- Buffers that response under WB backpressure.
- Aligns and sign/zero-extends load data, then emits the 70-bit ME->WB bus.
- Also drives the ME forwarding/stall bus toward the decoder.

Parameters:
- EX_BUS_W, 74, width of the EX->ME bus. Fixed by the layout below; not intended to be overridden.
- WB_BUS_W, 70, width of the ME->WB bus. Fixed.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ME_Allow_in  out  1  stage can accept this cycle
- EX_to_ME_Valid  in  1  EX bus valid
- EX_to_ME_Bus  in  74  {pc[73:42], gr_we[41], dest[40:36], alu_result[35:4], mem_req[3], load_op[2:0]}
- data_sram_data_ok  in  1  read-data return strobe, one per issued load, in order
- data_sram_rdata  in  32  returned word
- WB_Allow_in  in  1  WB can accept
- ME_to_WB_Valid  out  1  ME->WB bus valid
- ME_to_WB_Bus  out  70  {pc[69:38], gr_we[37], dest[36:32], final_result[31:0]}
- ME_Forward  out  38  {load_wait[37], ME_dest[36:32], final_result[31:0]}

Behaviour:
- Registers: ME_Valid, latched EX bus, buf_valid, buf_data[31:0]. Reset clears ME_Valid and buf_valid to 0. Datapath registers are don't-care.
- At reset, all outputs are valid-qualified to 0:
  - ME_to_WB_Valid = 0
  - ME_Forward[37:32] = 0
  - ME_Allow_in = 1
- Reset mid-wait drops the instruction. The memory side is reset together, so no stale data_ok arrives after reset.
- ME_ReadyGo = !mem_req || buf_valid || data_sram_data_ok.
- ME_Allow_in = !ME_Valid || (ME_ReadyGo && WB_Allow_in).
- ME_to_WB_Valid = ME_Valid && ME_ReadyGo.
- When ME_Allow_in, ME_Valid <= EX_to_ME_Valid.
- When EX_to_ME_Valid && ME_Allow_in:
  - latch the bus
  - clear buf_valid; this takes priority over buffer capture in the same cycle.
- Buffer capture: data_ok && ME_Valid && mem_req && !buf_valid && !WB_Allow_in -> buf_valid <= 1, buf_data <= rdata.
- Load word source: buf_valid ? buf_data : data_sram_rdata.
- States, derived from the registers:
  - EMPTY: !ME_Valid
  - WAIT: ME_Valid, mem_req, !buf_valid, no data_ok
  - READY: non-load, or data present
  - Transitions: EMPTY->WAIT/READY on accept. WAIT->READY on data_ok. READY->EMPTY or next instruction on WB_Allow_in.
- Load latency:
  - data_ok in cycle N with WB_Allow_in=1 -> result presented in cycle N, WB captures at N+1.
  - With WB_Allow_in=0, the data is held in the buffer until WB accepts.
- load_op encodings: 0 LD_B, 1 LD_H, 2 LD_W, 3 LD_BU, 4 LD_HU. Other codes are treated as LD_W.
- Offset = alu_result[1:0].
  - Bytes: select rdata[8*off+7 : 8*off].
  - Halves: select by off[1]; off[0] is ignored because EX traps misalignment.
  - B/H are sign-extended; BU/HU are zero-extended.
- final_result = mem_req ? aligned load data : alu_result.
- Bus outputs:
  - ME_to_WB_Bus = {pc, gr_we, dest, final_result}.
  - ME_dest = dest & {5{ME_Valid}}.
  - load_wait = ME_Valid && mem_req && !ME_ReadyGo. The decoder stalls on a dest match while load_wait=1.
- Simultaneous events:
  - data_ok together with WB accept: pass-through, no buffering.
  - data_ok while !mem_req or !ME_Valid is a protocol violation; flag it with an assertion and ignore it.
  - A second data_ok while buf_valid is an assertion violation.

Decomposition:
- Shared package:
  - LOAD_OP_* encodings
  - EX_BUS_W / WB_BUS_W / FWD_BUS_W
  - field-offset constants for both buses
- Sub-module me_load_align: combinational. Inputs are load_op, offset, and word; output is the extended 32-bit result.
- Stage control stays in me_stage_unit.

Test Plan:
- Non-load add, alu_result 0x0000_1234, dest 5, gr_we 1, WB_Allow_in=1 -> ME_to_WB_Valid next cycle with final_result 0x0000_1234. No load_wait.
- LD_B, addr off 3, data_ok with rdata 0x80FF_1234 -> final_result 0xFFFF_FF80. LD_BU at the same offset -> 0x0000_0080.
- LD_HU off 2 and LD_H off 0 on rdata 0x80FF_8001 -> 0x0000_80FF and 0xFFFF_8001.
- LD_W with data_ok delayed 3 cycles:
  - load_wait=1 and ME_Allow_in=0 for 3 cycles
  - ME_Forward dest shown
  - valid out in the cycle of data_ok
- WB_Allow_in=0 when data_ok arrives with rdata 0xDEAD_BEEF, released 2 cycles later:
  - buffered
  - ME_to_WB_Bus stays at 0xDEAD_BEEF
  - no second data_ok needed
- Back-to-back ALU, load, ALU with continuous EX valid: throughput 1/cycle except the load's wait cycles. Reset asserted mid-WAIT -> ME_Valid=0 the next cycle.
